// File: rtl/contador_param.sv
// contador_param: WIDTH-bit up / down / down-by-STEP / load counter.
// Q and rco are registered. zero is a combinational decode of Q.
// The carry-in gates only the three count modes, so several instances can be
// cascaded by feeding rco into the next stage's ci. The upper stage then lags
// the lower stage by one cycle, because rco is registered.
// sat selects between clamping at the boundary and wrapping modulo 2^WIDTH.
module contador_param #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    input  logic             ci,
    input  logic             sat,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             zero
);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_STEP = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    // Arithmetic is carried one bit wider than the counter. The top bit of
    // the result is the overflow or borrow flag that marks a boundary hit.
    localparam logic [WIDTH:0] ONE_X  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] STEP_X = {1'b0, STEP_W};

    logic [WIDTH:0]   dec_amount;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   diff_down;
    logic [WIDTH-1:0] q_next;
    logic             rco_next;

    assign sum_up    = {1'b0, Q} + ONE_X;
    assign diff_down = {1'b0, Q} - dec_amount;
    assign zero      = (Q == '0);

    // Pick the decrement amount for the two down modes.
    always_comb begin
        dec_amount = ONE_X;
        if (modo == MODO_STEP) begin
            dec_amount = STEP_X;
        end
    end

    // Next-state decode.
    // Hold, load and non-boundary counts all leave rco low.
    always_comb begin
        q_next   = Q;
        rco_next = 1'b0;
        if (enable) begin
            case (modo)
                MODO_LOAD: begin
                    q_next = D;
                end
                MODO_UP: begin
                    if (ci) begin
                        if (sum_up[WIDTH]) begin
                            rco_next = 1'b1;
                            q_next   = sat ? MAX_VAL : sum_up[WIDTH-1:0];
                        end else begin
                            q_next = sum_up[WIDTH-1:0];
                        end
                    end
                end
                MODO_DOWN, MODO_STEP: begin
                    if (ci) begin
                        if (diff_down[WIDTH]) begin
                            rco_next = 1'b1;
                            q_next   = sat ? '0 : diff_down[WIDTH-1:0];
                        end else begin
                            q_next = diff_down[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    q_next   = Q;
                    rco_next = 1'b0;
                end
            endcase
        end
    end

    // Count register and flag. Reset clears both immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q   <= '0;
            rco <= 1'b0;
        end else begin
            Q   <= q_next;
            rco <= rco_next;
        end
    end

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param.
// It covers a 4-bit instance, a two-stage 4-bit cascade and an 8-bit STEP=5
// instance. Expected results are queued when stimulus is driven. They are
// popped and compared one cycle later.
module tb_contador_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 4-bit, STEP=3 instance
    logic       en, ci, sat;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco, zero;

    contador_param #(.WIDTH(4), .STEP(3)) u_dut (
        .clk(clk), .reset(rst), .enable(en), .modo(modo), .D(d),
        .ci(ci), .sat(sat), .Q(q), .rco(rco), .zero(zero)
    );

    // two-stage cascade
    logic       c_en, c_sat, c_ci_lo;
    logic [1:0] c_modo;
    logic [3:0] c_d;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco, lo_zero, hi_zero;

    contador_param #(.WIDTH(4), .STEP(3)) u_lo (
        .clk(clk), .reset(rst), .enable(c_en), .modo(c_modo), .D(c_d),
        .ci(c_ci_lo), .sat(c_sat), .Q(lo_q), .rco(lo_rco), .zero(lo_zero)
    );

    contador_param #(.WIDTH(4), .STEP(3)) u_hi (
        .clk(clk), .reset(rst), .enable(c_en), .modo(c_modo), .D(c_d),
        .ci(lo_rco), .sat(c_sat), .Q(hi_q), .rco(hi_rco), .zero(hi_zero)
    );

    // 8-bit, STEP=5 instance
    logic       w_en, w_ci, w_sat;
    logic [1:0] w_modo;
    logic [7:0] w_d;
    logic [7:0] w_q;
    logic       w_rco, w_zero;

    contador_param #(.WIDTH(8), .STEP(5)) u_w8 (
        .clk(clk), .reset(rst), .enable(w_en), .modo(w_modo), .D(w_d),
        .ci(w_ci), .sat(w_sat), .Q(w_q), .rco(w_rco), .zero(w_zero)
    );

    typedef struct packed {
        logic       en;
        logic [1:0] modo;
        logic [7:0] d;
        logic       ci;
        logic       sat;
        logic [7:0] eq;
        logic       er;
    } stim_t;

    typedef struct packed {
        logic       rco;
        logic [7:0] q;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] csb[$];
    int         errors = 0;
    int         checks = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input stim_t s);
        en   = s.en;
        modo = s.modo;
        d    = s.d[3:0];
        ci   = s.ci;
        sat  = s.sat;
    endtask

    // Reference model.
    // It uses integer arithmetic on the current count and the inputs.
    function automatic exp_t model(input int w, input int step, input logic [7:0] cq,
                                   input logic e, input logic [1:0] m, input logic [7:0] dd,
                                   input logic c, input logic s);
        int   modv;
        int   maxv;
        int   qi;
        int   k;
        exp_t r;
        modv  = 1 << w;
        maxv  = modv - 1;
        qi    = int'(cq);
        r.rco = 1'b0;
        r.q   = cq;
        if (!e) return r;
        if (m == 2'b11) begin
            r.q = dd;
            return r;
        end
        if (!c) return r;
        if (m == 2'b00) begin
            if (qi == maxv) begin
                r.rco = 1'b1;
                r.q   = s ? 8'(maxv) : 8'd0;
            end else begin
                r.q = 8'(qi + 1);
            end
        end else begin
            k = (m == 2'b01) ? 1 : (step % modv);
            if (qi < k) begin
                r.rco = 1'b1;
                r.q   = s ? 8'd0 : 8'(qi - k + modv);
            end else begin
                r.q = 8'(qi - k);
            end
        end
        return r;
    endfunction

    task automatic test_reset;
        checks++;
        if (q !== 4'd0 || rco !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: got q=%0d rco=%b zero=%b, want q=0 rco=0 zero=1", q, rco, zero);
        end
        checks++;
        if (lo_q !== 4'd0 || hi_q !== 4'd0 || w_q !== 8'd0 || w_rco !== 1'b0) begin
            errors++;
            $display("FAIL reset_others: got lo=%0d hi=%0d w=%0d w_rco=%b, want all 0", lo_q, hi_q, w_q, w_rco);
        end
        tick();
        checks++;
        if (q !== 4'd0 || rco !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_edge: got q=%0d rco=%b, want q=0 rco=0", q, rco);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        exp_t e;
        for (int i = 0; i <= 9; i++) begin
            if (i == 0) begin
                en = 1'b1; modo = 2'b11; d = 4'd0; ci = 1'b1; sat = 1'b0;
            end else begin
                modo = 2'b00;
            end
            sb.push_back({1'b0, 8'(i)});
            tick();
            e = sb.pop_front();
            checks++;
            if ({rco, q} !== {e.rco, e.q[3:0]} || zero !== (e.q == 8'd0)) begin
                errors++;
                $display("FAIL count_to_9[%0d]: got q=%0d rco=%b zero=%b, want q=%0d rco=%b", i, q, rco, zero, e.q, e.rco);
            end
        end
        rst = 1'b1;
        #2;
        checks++;
        if (q !== 4'd0 || rco !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_run: got q=%0d rco=%b zero=%b, want q=0 rco=0 zero=1", q, rco, zero);
        end
        #1 rst = 1'b0;
        sb.push_back({1'b0, 8'd1});
        tick();
        e = sb.pop_front();
        checks++;
        if ({rco, q} !== {e.rco, e.q[3:0]}) begin
            errors++;
            $display("FAIL after_reset_up: got q=%0d rco=%b, want q=%0d rco=%b", q, rco, e.q, e.rco);
        end
    endtask

    task automatic test_wrap_up;
        stim_t t[4];
        exp_t  e;
        t = '{'{1'b1, 2'b11, 8'd14, 1'b1, 1'b0, 8'd14, 1'b0},
              '{1'b1, 2'b00, 8'd0,  1'b1, 1'b0, 8'd15, 1'b0},
              '{1'b1, 2'b00, 8'd0,  1'b1, 1'b0, 8'd0,  1'b1},
              '{1'b1, 2'b00, 8'd0,  1'b1, 1'b0, 8'd1,  1'b0}};
        foreach (t[i]) begin
            drive(t[i]);
            sb.push_back({t[i].er, t[i].eq});
            tick();
            e = sb.pop_front();
            checks++;
            if ({rco, q} !== {e.rco, e.q[3:0]} || zero !== (e.q == 8'd0)) begin
                errors++;
                $display("FAIL wrap_up[%0d]: got q=%0d rco=%b zero=%b, want q=%0d rco=%b", i, q, rco, zero, e.q, e.rco);
            end
        end
    endtask

    task automatic test_step_down;
        stim_t t[7];
        exp_t  e;
        t = '{'{1'b1, 2'b11, 8'd4, 1'b1, 1'b0, 8'd4,  1'b0},
              '{1'b1, 2'b10, 8'd0, 1'b1, 1'b0, 8'd1,  1'b0},
              '{1'b1, 2'b10, 8'd0, 1'b1, 1'b0, 8'd14, 1'b1},
              '{1'b1, 2'b11, 8'd4, 1'b1, 1'b1, 8'd4,  1'b0},
              '{1'b1, 2'b10, 8'd0, 1'b1, 1'b1, 8'd1,  1'b0},
              '{1'b1, 2'b10, 8'd0, 1'b1, 1'b1, 8'd0,  1'b1},
              '{1'b1, 2'b10, 8'd0, 1'b1, 1'b1, 8'd0,  1'b1}};
        foreach (t[i]) begin
            drive(t[i]);
            sb.push_back({t[i].er, t[i].eq});
            tick();
            e = sb.pop_front();
            checks++;
            if ({rco, q} !== {e.rco, e.q[3:0]} || zero !== (e.q == 8'd0)) begin
                errors++;
                $display("FAIL step_down[%0d]: got q=%0d rco=%b zero=%b, want q=%0d rco=%b", i, q, rco, zero, e.q, e.rco);
            end
        end
        // rco is high here; an asynchronous reset must clear it at once.
        rst = 1'b1;
        #2;
        checks++;
        if (rco !== 1'b0 || q !== 4'd0) begin
            errors++;
            $display("FAIL reset_clears_rco: got q=%0d rco=%b, want q=0 rco=0", q, rco);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_gating;
        stim_t t[7];
        exp_t  e;
        t = '{'{1'b1, 2'b11, 8'd7, 1'b1, 1'b0, 8'd7, 1'b0},
              '{1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 8'd7, 1'b0},
              '{1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 8'd7, 1'b0},
              '{1'b0, 2'b11, 8'd3, 1'b1, 1'b0, 8'd7, 1'b0},
              '{1'b0, 2'b00, 8'd3, 1'b1, 1'b0, 8'd7, 1'b0},
              '{1'b1, 2'b11, 8'd3, 1'b1, 1'b0, 8'd3, 1'b0},
              '{1'b1, 2'b11, 8'd9, 1'b0, 1'b1, 8'd9, 1'b0}};
        foreach (t[i]) begin
            drive(t[i]);
            sb.push_back({t[i].er, t[i].eq});
            tick();
            e = sb.pop_front();
            checks++;
            if ({rco, q} !== {e.rco, e.q[3:0]} || zero !== (e.q == 8'd0)) begin
                errors++;
                $display("FAIL gating[%0d]: got q=%0d rco=%b zero=%b, want q=%0d rco=%b", i, q, rco, zero, e.q, e.rco);
            end
        end
    endtask

    task automatic test_boundaries;
        stim_t t[16];
        exp_t  e;
        t = '{'{1'b1, 2'b11, 8'd15, 1'b1, 1'b1, 8'd15, 1'b0},
              '{1'b1, 2'b00, 8'd0,  1'b1, 1'b1, 8'd15, 1'b1},
              '{1'b1, 2'b00, 8'd0,  1'b1, 1'b1, 8'd15, 1'b1},
              '{1'b1, 2'b00, 8'd0,  1'b1, 1'b0, 8'd0,  1'b1},
              '{1'b1, 2'b00, 8'd0,  1'b1, 1'b0, 8'd1,  1'b0},
              '{1'b1, 2'b11, 8'd0,  1'b1, 1'b0, 8'd0,  1'b0},
              '{1'b1, 2'b01, 8'd0,  1'b1, 1'b0, 8'd15, 1'b1},
              '{1'b1, 2'b01, 8'd0,  1'b1, 1'b0, 8'd14, 1'b0},
              '{1'b1, 2'b11, 8'd0,  1'b1, 1'b1, 8'd0,  1'b0},
              '{1'b1, 2'b01, 8'd0,  1'b1, 1'b1, 8'd0,  1'b1},
              '{1'b1, 2'b11, 8'd3,  1'b1, 1'b0, 8'd3,  1'b0},
              '{1'b1, 2'b10, 8'd0,  1'b1, 1'b0, 8'd0,  1'b0},
              '{1'b1, 2'b10, 8'd0,  1'b1, 1'b0, 8'd13, 1'b1},
              '{1'b1, 2'b11, 8'd2,  1'b1, 1'b1, 8'd2,  1'b0},
              '{1'b1, 2'b10, 8'd0,  1'b1, 1'b1, 8'd0,  1'b1},
              '{1'b1, 2'b00, 8'd0,  1'b1, 1'b1, 8'd1,  1'b0}};
        foreach (t[i]) begin
            drive(t[i]);
            sb.push_back({t[i].er, t[i].eq});
            tick();
            e = sb.pop_front();
            checks++;
            if ({rco, q} !== {e.rco, e.q[3:0]} || zero !== (e.q == 8'd0)) begin
                errors++;
                $display("FAIL boundaries[%0d]: got q=%0d rco=%b zero=%b, want q=%0d rco=%b", i, q, rco, zero, e.q, e.rco);
            end
        end
    endtask

    task automatic test_cascade;
        exp_t       ln, hn;
        logic [7:0] lq, hq;
        logic       lr, hr;
        logic [9:0] ce;
        c_ci_lo = 1'b1; c_en = 1'b1; c_sat = 1'b0; c_modo = 2'b11; c_d = 4'd0;
        csb.push_back(10'd0);
        tick();
        ce = csb.pop_front();
        checks++;
        if ({hi_rco, hi_q, lo_rco, lo_q} !== ce) begin
            errors++;
            $display("FAIL cascade_load: got hi=%0d/%b lo=%0d/%b, want all 0", hi_q, hi_rco, lo_q, lo_rco);
        end
        lq = 8'd0; hq = 8'd0; lr = 1'b0; hr = 1'b0;
        c_modo = 2'b00;
        for (int n = 1; n <= 17; n++) begin
            ln = model(4, 3, lq, 1'b1, 2'b00, 8'd0, 1'b1, 1'b0);
            hn = model(4, 3, hq, 1'b1, 2'b00, 8'd0, lr, 1'b0);
            csb.push_back({hn.rco, hn.q[3:0], ln.rco, ln.q[3:0]});
            tick();
            ce = csb.pop_front();
            checks++;
            if ({hi_rco, hi_q, lo_rco, lo_q} !== ce) begin
                errors++;
                $display("FAIL cascade[%0d]: got hi=%0d/%b lo=%0d/%b, want hi=%0d/%b lo=%0d/%b",
                         n, hi_q, hi_rco, lo_q, lo_rco, ce[8:5], ce[9], ce[3:0], ce[4]);
            end
            if (n == 16) begin
                checks++;
                if (hi_q !== 4'd0 || lo_q !== 4'd0 || lo_rco !== 1'b1) begin
                    errors++;
                    $display("FAIL cascade_lag: got hi=%0d lo=%0d lo_rco=%b, want hi=0 lo=0 lo_rco=1", hi_q, lo_q, lo_rco);
                end
            end
            if (n == 17) begin
                checks++;
                if (hi_q !== 4'd1 || lo_q !== 4'd1) begin
                    errors++;
                    $display("FAIL cascade_17: got hi=%0d lo=%0d, want hi=1 lo=1", hi_q, lo_q);
                end
            end
            lq = ln.q; lr = ln.rco; hq = hn.q; hr = hn.rco;
        end
        c_en = 1'b0;
    endtask

    task automatic test_width8;
        stim_t t[8];
        exp_t  e;
        t = '{'{1'b1, 2'b11, 8'd2,   1'b1, 1'b0, 8'd2,   1'b0},
              '{1'b1, 2'b10, 8'd0,   1'b1, 1'b0, 8'd253, 1'b1},
              '{1'b1, 2'b11, 8'd255, 1'b1, 1'b0, 8'd255, 1'b0},
              '{1'b1, 2'b00, 8'd0,   1'b1, 1'b0, 8'd0,   1'b1},
              '{1'b1, 2'b11, 8'd4,   1'b1, 1'b1, 8'd4,   1'b0},
              '{1'b1, 2'b10, 8'd0,   1'b1, 1'b1, 8'd0,   1'b1},
              '{1'b1, 2'b11, 8'd5,   1'b1, 1'b0, 8'd5,   1'b0},
              '{1'b1, 2'b10, 8'd0,   1'b1, 1'b0, 8'd0,   1'b0}};
        foreach (t[i]) begin
            w_en = t[i].en; w_modo = t[i].modo; w_d = t[i].d; w_ci = t[i].ci; w_sat = t[i].sat;
            sb.push_back({t[i].er, t[i].eq});
            tick();
            e = sb.pop_front();
            checks++;
            if ({w_rco, w_q} !== {e.rco, e.q} || w_zero !== (e.q == 8'd0)) begin
                errors++;
                $display("FAIL width8[%0d]: got q=%0d rco=%b zero=%b, want q=%0d rco=%b", i, w_q, w_rco, w_zero, e.q, e.rco);
            end
        end
        w_en = 1'b0;
    endtask

    task automatic test_random;
        exp_t       e;
        exp_t       nx;
        logic [7:0] mq;
        mq = 8'd0;
        for (int i = 0; i < 300; i++) begin
            if (i == 0) begin
                en = 1'b1; modo = 2'b11; ci = 1'b0;
            end else begin
                en   = ($urandom_range(0, 7) != 0);
                modo = 2'($urandom_range(0, 3));
                ci   = ($urandom_range(0, 3) != 0);
            end
            d   = 4'($urandom_range(0, 15));
            sat = 1'($urandom_range(0, 1));
            nx  = model(4, 3, mq, en, modo, {4'd0, d}, ci, sat);
            sb.push_back(nx);
            tick();
            e = sb.pop_front();
            checks++;
            if ({rco, q} !== {e.rco, e.q[3:0]} || zero !== (e.q == 8'd0)) begin
                errors++;
                $display("FAIL random[%0d]: got q=%0d rco=%b zero=%b, want q=%0d rco=%b", i, q, rco, zero, e.q, e.rco);
            end
            mq = e.q;
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0; modo = 2'b00; d = 4'd0; ci = 1'b0; sat = 1'b0;
        c_en = 1'b0; c_modo = 2'b00; c_d = 4'd0; c_ci_lo = 1'b1; c_sat = 1'b0;
        w_en = 1'b0; w_modo = 2'b00; w_d = 8'd0; w_ci = 1'b1; w_sat = 1'b0;
        #1 rst = 1'b1;
        #1;
        test_reset();
        test_reset_mid_run();
        test_wrap_up();
        test_step_down();
        test_gating();
        test_boundaries();
        test_cascade();
        test_width8();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_param.md
Name: contador_param

Overview:
- Parametrised successor of the 4-bit mode counter used in tarea3.
- Synchronous up/down/step/load counter of WIDTH bits with a registered ripple-carry flag (rco).
- Adds a carry-in (ci) for cascading several instances, and a per-cycle saturate-instead-of-wrap option.
- Sits under the same driver/checker/scoreboard bench flow; the scoreboard model is updated to match.

Parameters:
- WIDTH, 4, counter and load-data width in bits (≥2).
- STEP, 3, decrement applied in mode 2'b10; must satisfy 1 ≤ STEP < 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global enable; low = hold.
- modo  input  2  operating mode (see Behaviour).
- D  input  WIDTH  parallel load value.
- ci  input  1  carry-in; gates count modes only; tie high when not cascaded.
- sat  input  1  1 = saturate at boundary; 0 = wrap modulo 2^WIDTH.
- Q  output  WIDTH  registered count.
- rco  output  1  registered ripple-carry/borrow flag.
- zero  output  1  combinational, high when Q == 0.

Behaviour:
- Reset (async, any time, including mid-count): Q=0 and rco=0 immediately. First update occurs on the first clk edge after reset deasserts.
- All updates on rising clk edge. Latency: Q and rco reflect the inputs sampled at edge N right after edge N (1 cycle).
- MAX = 2^WIDTH-1.
- Modes, applied when enable=1:
  - 2'b00, up by 1, requires ci=1.
  - 2'b01, down by 1, requires ci=1.
  - 2'b10, down by STEP, requires ci=1.
  - 2'b11, load Q=D; ci and sat are ignored.
- Hold (Q unchanged, rco=0):
  - enable=0, regardless of other inputs.
  - enable=1 with a count mode and ci=0.
- Boundary conditions:
  - Overflow (up): Q==MAX.
  - Underflow (down by k, k=1 or STEP): Q < k.
- Boundary with sat=0: wrap.
  - up: Q=0.
  - down: Q=(Q-k) mod 2^WIDTH, e.g. WIDTH=4, STEP=3, Q=1 → 14.
- Boundary with sat=1: clamp.
  - up: Q=MAX.
  - down: Q=0.
- rco:
  - 1 for exactly the cycle following an update that hit a boundary, whether wrap or clamp.
  - 0 after every non-boundary update, load, or hold.
  - Repeated boundary hits while saturated (e.g. Q held at MAX counting up) assert rco every cycle.
- Load of any value, including MAX or 0, never asserts rco.
- Cascading: feed stage i rco into stage i+1 ci, with stages sharing modo ∈ {00,01}. Because rco is registered, the upper stage lags by one cycle. This is accepted behaviour; the bench models it.
- Width rules:
  - All arithmetic is done in WIDTH+1 bits; the extra bit is the boundary flag.
  - STEP is truncated to WIDTH bits at elaboration.
- No X on outputs after reset. Inputs are assumed to be driven and non-X.

Test Plan:
- Reset mid-run: WIDTH=4, count up to Q=9, pulse reset between edges → Q=0 and rco=0 without waiting for a clk edge. Next up-count edge → Q=1.
- Wrap up: load D=14, then modo=00, ci=1, sat=0 for 3 cycles → Q sequence 15, 0, 1. rco=1 only in the cycle Q=0.
- Step down wrap and saturate: load 4, modo=10, STEP=3.
  - sat=0 → Q=1, then 14 with rco=1.
  - Repeat with sat=1 → Q=1, then 0 with rco=1, then 0 with rco=1.
- Gating: Q=7, modo=01.
  - ci=0 for 2 cycles → Q holds 7, rco=0.
  - enable=0 with modo=11, D=3 → Q holds 7.
  - enable=1 → Q=3.
- Cascade: two 4-bit instances, low stage ci=1, high stage ci=low.rco, count up from 0 → after 17 edges: high.Q=1, low.Q=1 (one-cycle lag at the carry edge is checked).
- Parameter sweep: WIDTH=8, STEP=5, start from Q=2, down by STEP with sat=0 → Q=253, rco=1. Load D=255, then up → Q=0, rco=1.
